// File: rtl/boot_run_ctrl_pkg.sv
// Shared state encoding and word geometry for boot_run_ctrl and its dump packer.
package boot_run_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RST_HOLD,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_OUT,
    ST_DONE
  } state_e;

  function automatic logic is_busy(state_e s);
    return !(s == ST_IDLE || s == ST_DONE);
  endfunction

endpackage

// File: rtl/boot_run_ctrl_if.sv
// Load stream, memory port and dump stream of boot_run_ctrl.
// The master modport is the controller side.
interface boot_run_ctrl_if #(
  parameter int ADDR_W = 6
) ();

  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  logic              dump_valid;
  logic [31:0]       dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_ready;

  modport master (
    input  ld_valid, ld_data, mem_rdata, dump_ready,
    output ld_ready, mem_addr, mem_wdata, mem_we, mem_re,
           dump_valid, dump_data, dump_addr
  );

  modport slave (
    output ld_valid, ld_data, mem_rdata, dump_ready,
    input  ld_ready, mem_addr, mem_wdata, mem_we, mem_re,
           dump_valid, dump_data, dump_addr
  );

endinterface

// File: rtl/boot_run_ctrl_dump_word_pack.sv
// Assembles one big-endian dump word from four byte reads that return
// one cycle after each mem_re pulse.
module dump_word_pack
  import boot_run_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_issued_i,
  input  logic [7:0]                  rdata_i,
  output logic [8*BYTES_PER_WORD-1:0] word_o
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;

  logic              rd_pending_q;
  logic [WORD_W-1:0] word_q;

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  // The assembly register is cleared on reset so an abandoned dump never
  // leaves a stale partial word on dump_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending_q <= 1'b0;
      word_q       <= '0;
    end else begin
      rd_pending_q <= rd_issued_i;
      if (rd_pending_q) word_q <= {word_q[WORD_W-9:0], rdata_i};
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/boot_run_ctrl.sv
// Loads a memory image, holds the CPU in reset, runs it for a cycle budget,
// then dumps memory as 32-bit words. Optional: BOOT_RUN_EARLY_HALT_EN adds cpu_halt.
module boot_run_ctrl
  import boot_run_pkg::*;
#(
  parameter int DEPTH      = 56,
  parameter int ADDR_W     = 6,
  parameter int RUN_W      = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [RUN_W-1:0] run_cycles,
`ifdef BOOT_RUN_EARLY_HALT_EN
  input  logic             cpu_halt,
`endif
  output logic             cpu_reset,
  output logic             cpu_clk_en,
  output logic             busy,
  output logic             done,
  output logic [RUN_W-1:0] cycle_count,
  boot_run_ctrl_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - BYTES_PER_WORD);
  localparam int                HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RUN_W-1:0]  budget_q, budget_d;
  logic [RUN_W-1:0]  count_q, count_d, count_inc;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        rd_idx_q, rd_idx_d;
  logic              halt;
  logic [31:0]       word;

`ifdef BOOT_RUN_EARLY_HALT_EN
  assign halt = cpu_halt;
`else
  assign halt = 1'b0;
`endif

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign count_inc = (count_q == '1) ? count_q : count_q + RUN_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      budget_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      budget_q <= budget_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    budget_d       = budget_q;
    count_d        = count_q;
    hold_d         = hold_q;
    rd_idx_d       = rd_idx_q;
    bus.ld_ready   = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = bus.ld_data;
    bus.dump_valid = 1'b0;
    cpu_clk_en     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_LOAD;
          addr_d   = '0;
          budget_d = run_cycles;
          count_d  = '0;
        end
      end
      ST_LOAD: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_valid) begin
          bus.mem_we = 1'b1;
          if (addr_q == LAST_BYTE) begin
            addr_d  = '0;
            hold_d  = '0;
            state_d = ST_RST_HOLD;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          rd_idx_d = '0;
          state_d  = (budget_q == '0) ? ST_DUMP_RD : ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        cpu_clk_en = 1'b1;
        count_d    = count_inc;
        if (count_inc == budget_q || halt) begin
          addr_d   = '0;
          rd_idx_d = '0;
          state_d  = ST_DUMP_RD;
        end
      end
      ST_DUMP_RD: begin
        // Four reads on idx 0..3; idx 4 waits for the last byte to land.
        if (rd_idx_q < 3'(BYTES_PER_WORD)) begin
          bus.mem_re   = 1'b1;
          bus.mem_addr = addr_q + ADDR_W'(rd_idx_q);
          rd_idx_d     = rd_idx_q + 3'd1;
        end else begin
          state_d = ST_DUMP_OUT;
        end
      end
      ST_DUMP_OUT: begin
        bus.dump_valid = 1'b1;
        if (bus.dump_ready) begin
          rd_idx_d = '0;
          if (addr_q == LAST_WORD) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(BYTES_PER_WORD);
            state_d = ST_DUMP_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dump_word_pack u_pack (
    .clk         (clk),
    .reset       (reset),
    .rd_issued_i (bus.mem_re),
    .rdata_i     (bus.mem_rdata),
    .word_o      (word)
  );

  assign bus.dump_data = word;
  assign bus.dump_addr = addr_q;
  assign cpu_reset     = (state_q != ST_RUN);
  assign busy          = is_busy(state_q);
  assign done          = (state_q == ST_DONE);
  assign cycle_count   = count_q;

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Self-checking bench for boot_run_ctrl: random load/dump handshakes scored
// against an image-level model of what the memory and dump stream must show.
module tb_boot_run_ctrl;
  import boot_run_pkg::*;

  localparam int DEPTH  = 8;
  localparam int AW     = 4;
  localparam int RW     = 16;
  localparam int RSTC   = 4;
  localparam int WORDS  = DEPTH / BYTES_PER_WORD;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] run_cycles = '0;
  logic          cpu_reset, cpu_clk_en, busy, done;
  logic [RW-1:0] cycle_count;
`ifdef BOOT_RUN_EARLY_HALT_EN
  logic          cpu_halt = 1'b0;
`endif

  boot_run_ctrl_if #(.ADDR_W(AW)) bus ();

  boot_run_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .RUN_W(RW), .RST_CYCLES(RSTC)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .run_cycles  (run_cycles),
`ifdef BOOT_RUN_EARLY_HALT_EN
    .cpu_halt    (cpu_halt),
`endif
    .cpu_reset   (cpu_reset),
    .cpu_clk_en  (cpu_clk_en),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  // Byte memory: read data appears one cycle after mem_re, noise otherwise.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[2:0]] <= bus.mem_wdata;
    bus.mem_rdata <= bus.mem_re ? mem[bus.mem_addr[2:0]] : 8'($urandom);
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]    img [DEPTH];
  logic [AW-1:0] we_addr[$];
  logic [7:0]    we_data[$];
  logic [AW-1:0] re_addr[$];
  logic [31:0]   dw_data[$];
  logic [AW-1:0] dw_addr[$];
  int            en_n, rst_hold_n, ready_late_n, both_n, stall_n, re_in_out_n, busy_bad_n, en_rst_n;
  logic          timed_out;
  logic [RW-1:0] final_count;

  function automatic logic [31:0] exp_word(int w);
    return {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
  endfunction

  task automatic rand_image();
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
  endtask

  // Runs one start..done sequence and records what was observed.
  task automatic do_seq(input logic [RW-1:0] rc, input int vprob, input int rprob,
                        input bit noise, input int halt_at, input bit abort2, input bit hold10);
    int   nb, low_left;
    bit   loaded, ran, held, low_armed;
    logic [31:0]   hd;
    logic [AW-1:0] ha;
    we_addr.delete(); we_data.delete(); re_addr.delete(); dw_data.delete(); dw_addr.delete();
    en_n = 0; rst_hold_n = 0; ready_late_n = 0; both_n = 0; stall_n = 0;
    re_in_out_n = 0; busy_bad_n = 0; en_rst_n = 0;
    nb = 0; low_left = 0; loaded = 0; ran = 0; held = 0; low_armed = 0;
    hd = '0; ha = '0; timed_out = 1'b1; final_count = '0;
    @(posedge clk); #1;
    start = 1'b1; run_cycles = rc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      if (abort2 && dw_data.size() == 1 && bus.dump_valid) begin
        bus.dump_ready = 1'b0;
        bus.ld_valid   = 1'b0;
        timed_out      = 1'b0;
        break;
      end
      start      = noise && !done && ($urandom_range(0, 3) == 0);
      run_cycles = RW'($urandom);
      bus.ld_valid = (nb < DEPTH) ? ($urandom_range(1, 100) <= vprob) : 1'($urandom);
      bus.ld_data  = (nb < DEPTH) ? img[nb] : 8'($urandom);
      if (hold10 && !low_armed && bus.dump_valid) begin
        low_armed = 1'b1;
        low_left  = 10;
      end
      bus.dump_ready = (low_left > 0) ? 1'b0 : ($urandom_range(1, 100) <= rprob);
      if (low_left > 0) low_left--;
`ifdef BOOT_RUN_EARLY_HALT_EN
      cpu_halt = cpu_clk_en && (en_n + 1 == halt_at);
`endif
      #1;
      if (bus.mem_we && bus.mem_re) both_n++;
      if (cpu_clk_en && cpu_reset) en_rst_n++;
      if (loaded && !ran && cpu_reset && !cpu_clk_en) rst_hold_n++;
      if (cpu_clk_en) begin en_n++; ran = 1'b1; end
      if (loaded && bus.ld_ready) ready_late_n++;
      if (bus.mem_we) begin we_addr.push_back(bus.mem_addr); we_data.push_back(bus.mem_wdata); end
      if (bus.ld_valid && bus.ld_ready) nb++;
      if (nb == DEPTH) loaded = 1'b1;
      if (bus.mem_re) re_addr.push_back(bus.mem_addr);
      if (bus.mem_re && bus.dump_valid) re_in_out_n++;
      if (held && (!bus.dump_valid || bus.dump_data !== hd || bus.dump_addr !== ha)) stall_n++;
      if (bus.dump_valid && bus.dump_ready) begin
        dw_data.push_back(bus.dump_data); dw_addr.push_back(bus.dump_addr);
      end
      held = bus.dump_valid && !bus.dump_ready;
      hd = bus.dump_data; ha = bus.dump_addr;
      if (busy !== !done) busy_bad_n++;
      if (done) begin final_count = cycle_count; timed_out = 1'b0; break; end
    end
    start = 1'b0; bus.ld_valid = 1'b0; bus.dump_ready = 1'b0;
`ifdef BOOT_RUN_EARLY_HALT_EN
    cpu_halt = 1'b0;
`endif
    if (halt_at < 0) $display("note: halt_at ignored");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'($urandom); bus.ld_valid = 1'($urandom); bus.dump_ready = 1'($urandom);
    end
    #1;
    n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL rst_cpu_reset got %b want 1", cpu_reset); end
    n_cmp++; if (cpu_clk_en !== 1'b0) begin n_err++; $display("FAIL rst_clk_en got %b want 0", cpu_clk_en); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.mem_re !== 1'b0) begin n_err++; $display("FAIL rst_mem_re got %b want 0", bus.mem_re); end
    n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL rst_ld_ready got %b want 0", bus.ld_ready); end
    n_cmp++; if (bus.dump_valid !== 1'b0) begin n_err++; $display("FAIL rst_dump_valid got %b want 0", bus.dump_valid); end
    n_cmp++; if (bus.dump_data !== 32'h0) begin n_err++; $display("FAIL rst_dump_data got %h want 0", bus.dump_data); end
    n_cmp++; if (bus.dump_addr !== '0) begin n_err++; $display("FAIL rst_addr got %0d want 0", bus.dump_addr); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (cycle_count !== '0) begin n_err++; $display("FAIL rst_count got %0d want 0", cycle_count); end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; bus.ld_valid = 1'b0; bus.dump_ready = 1'b0;
  endtask

  task automatic test_load_run_dump();
    img = '{8'h9C, 8'h04, 8'h40, 8'h12, 8'hA2, 8'h04, 8'h40, 8'h12};
    do_seq(RW'(5), 100, 100, 1'b0, 0, 1'b0, 1'b0);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL lrd_timeout got %b want 0", timed_out); end
    n_cmp++; if (we_addr.size() != DEPTH) begin n_err++; $display("FAIL lrd_we_count got %0d want %0d", we_addr.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (i >= we_addr.size() || we_addr[i] !== AW'(i) || we_data[i] !== img[i]) begin
        n_err++; $display("FAIL lrd_write[%0d] got %0d:%h want %0d:%h", i,
          (i < we_addr.size()) ? we_addr[i] : AW'(0), (i < we_data.size()) ? we_data[i] : 8'h0, i, img[i]);
      end
    end
    n_cmp++; if (ready_late_n != 0) begin n_err++; $display("FAIL lrd_ready_after_load got %0d cycles want 0", ready_late_n); end
    n_cmp++; if (rst_hold_n != RSTC) begin n_err++; $display("FAIL lrd_rst_hold got %0d want %0d", rst_hold_n, RSTC); end
    n_cmp++; if (en_n != 5) begin n_err++; $display("FAIL lrd_clk_en_cycles got %0d want 5", en_n); end
    n_cmp++; if (en_rst_n != 0) begin n_err++; $display("FAIL lrd_en_with_rst got %0d want 0", en_rst_n); end
    n_cmp++; if (final_count !== RW'(5)) begin n_err++; $display("FAIL lrd_cycle_count got %0d want 5", final_count); end
    n_cmp++; if (dw_data.size() != WORDS) begin n_err++; $display("FAIL lrd_words got %0d want %0d", dw_data.size(), WORDS); end
    n_cmp++; if (dw_data.size() > 0 && (dw_data[0] !== 32'h9C044012 || dw_addr[0] !== AW'(0)))
      begin n_err++; $display("FAIL lrd_word0 got %h@%0d want 9c044012@0", dw_data[0], dw_addr[0]); end
    n_cmp++; if (dw_data.size() > 1 && (dw_data[1] !== 32'hA2044012 || dw_addr[1] !== AW'(4)))
      begin n_err++; $display("FAIL lrd_word1 got %h@%0d want a2044012@4", dw_data[1], dw_addr[1]); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (i >= re_addr.size() || re_addr[i] !== AW'(i)) begin
        n_err++; $display("FAIL lrd_read_addr[%0d] got %0d want %0d", i, (i < re_addr.size()) ? re_addr[i] : AW'(0), i);
      end
    end
    n_cmp++; if (both_n != 0 || busy_bad_n != 0) begin n_err++; $display("FAIL lrd_we_re_busy got %0d/%0d want 0/0", both_n, busy_bad_n); end
    repeat (3) begin @(posedge clk); #1; start = 1'b0; end
    #1;
    n_cmp++; if (done !== 1'b1 || cycle_count !== RW'(5)) begin n_err++; $display("FAIL lrd_done_hold got %b/%0d want 1/5", done, cycle_count); end
  endtask

  task automatic test_backpressure();
    rand_image();
    do_seq(RW'(3), 70, 100, 1'b0, 0, 1'b0, 1'b1);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL bp_timeout got %b want 0", timed_out); end
    n_cmp++; if (stall_n != 0) begin n_err++; $display("FAIL bp_stable got %0d changes want 0", stall_n); end
    n_cmp++; if (re_in_out_n != 0) begin n_err++; $display("FAIL bp_re_while_valid got %0d want 0", re_in_out_n); end
    n_cmp++; if (re_addr.size() != DEPTH) begin n_err++; $display("FAIL bp_re_count got %0d want %0d", re_addr.size(), DEPTH); end
    for (int w = 0; w < WORDS; w++) begin
      n_cmp++;
      if (w >= dw_data.size() || dw_data[w] !== exp_word(w) || dw_addr[w] !== AW'(4*w)) begin
        n_err++; $display("FAIL bp_word[%0d] got %h want %h", w, (w < dw_data.size()) ? dw_data[w] : 32'h0, exp_word(w));
      end
    end
  endtask

  task automatic test_zero_run();
    rand_image();
    do_seq(RW'(0), 100, 60, 1'b0, 0, 1'b0, 1'b0);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL zr_timeout got %b want 0", timed_out); end
    n_cmp++; if (en_n != 0) begin n_err++; $display("FAIL zr_clk_en got %0d cycles want 0", en_n); end
    n_cmp++; if (final_count !== '0) begin n_err++; $display("FAIL zr_count got %0d want 0", final_count); end
    for (int w = 0; w < WORDS; w++) begin
      n_cmp++;
      if (w >= dw_data.size() || dw_data[w] !== exp_word(w)) begin
        n_err++; $display("FAIL zr_word[%0d] got %h want %h", w, (w < dw_data.size()) ? dw_data[w] : 32'h0, exp_word(w));
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    rand_image();
    do_seq(RW'(2), 100, 100, 1'b0, 0, 1'b1, 1'b0);
    n_cmp++; if (timed_out !== 1'b0 || dw_data.size() != 1) begin n_err++; $display("FAIL rmd_reach got %0d words want 1", dw_data.size()); end
    reset = 1'b1;
    @(posedge clk); #2;
    n_cmp++; if (bus.dump_valid !== 1'b0) begin n_err++; $display("FAIL rmd_dump_valid got %b want 0", bus.dump_valid); end
    n_cmp++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin n_err++; $display("FAIL rmd_idle got rst=%b busy=%b done=%b want 1/0/0", cpu_reset, busy, done); end
    n_cmp++; if (bus.dump_data !== 32'h0) begin n_err++; $display("FAIL rmd_dump_data got %h want 0", bus.dump_data); end
    reset = 1'b0;
    rand_image();
    do_seq(RW'(4), 80, 80, 1'b0, 0, 1'b0, 1'b0);
    n_cmp++; if (timed_out !== 1'b0 || final_count !== RW'(4)) begin n_err++; $display("FAIL rmd_rerun got %0d want 4", final_count); end
    for (int w = 0; w < WORDS; w++) begin
      n_cmp++;
      if (w >= dw_data.size() || dw_data[w] !== exp_word(w)) begin
        n_err++; $display("FAIL rmd_word[%0d] got %h want %h", w, (w < dw_data.size()) ? dw_data[w] : 32'h0, exp_word(w));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] rc;
    for (int it = 0; it < 8; it++) begin
      rand_image();
      rc = RW'($urandom_range(0, 30));
      do_seq(rc, $urandom_range(30, 100), $urandom_range(20, 100), 1'b1, 0, 1'b0, 1'b0);
      n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL b2b[%0d]_timeout", it); end
      n_cmp++; if (en_n != int'(rc) || final_count !== rc)
        begin n_err++; $display("FAIL b2b[%0d]_run got %0d/%0d want %0d", it, en_n, final_count, rc); end
      n_cmp++; if (we_addr.size() != DEPTH || stall_n != 0 || both_n != 0 || busy_bad_n != 0 || en_rst_n != 0)
        begin n_err++; $display("FAIL b2b[%0d]_proto we=%0d stall=%0d both=%0d busy=%0d enrst=%0d", it,
                                we_addr.size(), stall_n, both_n, busy_bad_n, en_rst_n); end
      for (int w = 0; w < WORDS; w++) begin
        n_cmp++;
        if (w >= dw_data.size() || dw_data[w] !== exp_word(w) || dw_addr[w] !== AW'(4*w)) begin
          n_err++; $display("FAIL b2b[%0d]_word[%0d] got %h want %h", it, w, (w < dw_data.size()) ? dw_data[w] : 32'h0, exp_word(w));
        end
      end
    end
  endtask

`ifdef BOOT_RUN_EARLY_HALT_EN
  task automatic test_halt();
    rand_image();
    do_seq(RW'(100), 100, 100, 1'b0, 3, 1'b0, 1'b0);
    n_cmp++; if (timed_out !== 1'b0 || final_count !== RW'(3)) begin n_err++; $display("FAIL halt_count got %0d want 3", final_count); end
    n_cmp++; if (en_n != 3) begin n_err++; $display("FAIL halt_clk_en got %0d want 3", en_n); end
    for (int w = 0; w < WORDS; w++) begin
      n_cmp++;
      if (w >= dw_data.size() || dw_data[w] !== exp_word(w)) begin
        n_err++; $display("FAIL halt_word[%0d] got %h want %h", w, (w < dw_data.size()) ? dw_data[w] : 32'h0, exp_word(w));
      end
    end
  endtask
`endif

  initial begin
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.dump_ready = 1'b0;
    test_reset();
    test_load_run_dump();
    test_backpressure();
    test_zero_run();
    test_reset_mid_dump();
    test_back_to_back();
`ifdef BOOT_RUN_EARLY_HALT_EN
    test_halt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boot_run_ctrl.md
BOOT_RUN_CTRL -- requirements
Module: boot_run_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 56, meaning memory image size in bytes; multiple of 4, minimum 4.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning byte-address width, with 2^ADDR_W >= DEPTH.
REQ-003 SHALL have parameter RUN_W, default 16, meaning run-cycle counter width.
REQ-004 SHALL have parameter RST_CYCLES, default 4, meaning number of cycles cpu_reset is held after load; minimum 1.
REQ-005 SHALL use one clock; reset is synchronous and active-high: Clk  in  1  rising-edge clock; Reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports start in 1 (begin a sequence, sampled in IDLE) and run_cycles in RUN_W (CPU cycle budget, latched on start).
REQ-007 SHALL have load-stream ports ld_valid in 1, ld_data in 8 and ld_ready out 1.
REQ-008 SHALL have memory ports mem_addr out ADDR_W, mem_wdata out 8, mem_we out 1, mem_re out 1 and mem_rdata in 8 (data valid exactly 1 cycle after mem_re).
REQ-009 SHALL have CPU control ports cpu_reset out 1 (active-high to CPU) and cpu_clk_en out 1.
REQ-010 SHALL have dump ports dump_valid out 1, dump_data out 32, dump_addr out ADDR_W (byte address of word) and dump_ready in 1.
REQ-011 SHALL have status ports busy out 1, done out 1 and cycle_count out RUN_W.

Function
REQ-012 SHALL implement states IDLE, LOAD, RST_HOLD, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-013 IDLE: start=1 SHALL latch run_cycles, clear the address to 0 and go to LOAD; in all other states start SHALL be ignored.
REQ-014 LOAD: ld_ready=1; each ld_valid&ld_ready cycle SHALL set mem_we=1, mem_wdata=ld_data and mem_addr=addr in that same cycle, then increment addr; after byte DEPTH-1 SHALL go to RST_HOLD.
REQ-015 RST_HOLD: cpu_reset=1 and cpu_clk_en=0 for exactly RST_CYCLES cycles, then SHALL go to RUN (or straight to DUMP_RD if the latched run_cycles==0).
REQ-016 RUN: cpu_reset=0 and cpu_clk_en=1; cycle_count SHALL increment once per cycle, and when it equals the latched run_cycles SHALL set cpu_clk_en=0 and go to DUMP_RD with addr=0.
REQ-017 DUMP_RD: SHALL issue 4 consecutive mem_re pulses at addr..addr+3, packed big-endian (byte addr to [31:24]); the word is complete 1 cycle after the last read, then SHALL go to DUMP_OUT.
REQ-018 DUMP_OUT: dump_valid=1 with dump_data and dump_addr stable until dump_ready; on handshake SHALL advance addr by 4 and go to DUMP_RD, or to DONE after word DEPTH/4-1.
REQ-019 DONE: done=1, holding cycle_count; start=1 SHALL re-enter LOAD as from IDLE.
REQ-020 busy SHALL be 1 in all states except IDLE and DONE; cpu_reset SHALL be 1 in every state except RUN.
REQ-021 cycle_count SHALL saturate at all-ones and never wrap; mem_we and mem_re SHALL never be high together.

Reset
REQ-022 Reset=1 at any clock edge SHALL force IDLE regardless of state, giving cpu_reset=1 and zero for cpu_clk_en, mem_we, mem_re, ld_ready, dump_valid, dump_data, done, busy, cycle_count and addr.
REQ-023 Reset mid-LOAD or mid-DUMP SHALL abandon the sequence; memory contents are unspecified, and no partial word SHALL be emitted.

Configuration
REQ-024 When macro BOOT_RUN_EARLY_HALT_EN is defined, the block SHALL add input cpu_halt (1 bit); cpu_halt=1 in RUN SHALL end RUN on that edge (cpu_clk_en=0 the next cycle) and freeze cycle_count at its current value.
REQ-025 When BOOT_RUN_EARLY_HALT_EN is undefined, the cpu_halt port SHALL be absent and RUN SHALL always last exactly the latched run_cycles cycles.

Structure
REQ-026 Package boot_run_pkg SHALL hold the state enum and the constant BYTES_PER_WORD=4.
REQ-027 Sub-module dump_word_pack SHALL hold the byte-lane shift and 32-bit assembly register, cleared on Reset.

Verification
REQ-028 DEPTH=8, bytes 9C 04 40 12 A2 04 40 12 streamed with ld_valid always high: exactly 8 mem_we pulses at addr 0..7 and ld_ready low afterwards.
REQ-029 run_cycles=5, RST_CYCLES=4: cpu_reset high for 4 cycles after load, cpu_clk_en high for exactly 5 cycles, cycle_count=5 in DONE.
REQ-030 Memory preset to the above image with dump_ready always 1: dump words 9C044012@0 then A2044012@4, followed by done=1.
REQ-031 dump_ready held low 10 cycles: dump_valid/data/addr stable throughout, and no extra mem_re pulses.
REQ-032 run_cycles=0: RUN is skipped and cpu_clk_en is never asserted; with BOOT_RUN_EARLY_HALT_EN, cpu_halt on the 3rd RUN cycle with run_cycles=100 gives cycle_count=3.
REQ-033 Reset asserted during the 2nd dump word: the next cycle shows IDLE, dump_valid=0 and cpu_reset=1; a fresh start then completes normally.
